wf_rr_issue_arbiter: RTL and testbench



---
 rtl/wf_rr_issue_arbiter.sv | 106 ++++++++++
 tb/tb_wf_rr_issue_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wf_rr_issue_arbiter.sv
// Rotating-priority wavefront issue arbiter with a registered single-cycle grant.
// Optional starvation-age boost when RR_ARB_STARVE_BOOST_EN is defined.
module wf_rr_issue_arbiter #(
  parameter int NUM_WF       = 40,
  parameter int WF_ID_W      = 6,
  parameter int STARVE_LIMIT = 15,
  parameter int AGE_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  ready_arry,
  input  logic               fu_ready,
  input  logic               issued_en,
  input  logic [WF_ID_W-1:0] issued_wf_id,
  output logic               choosen_valid,
  output logic [WF_ID_W-1:0] choosen_wf_id,
  output logic [WF_ID_W-1:0] rr_ptr
);

  if (((1 << AGE_W) - 1) < STARVE_LIMIT) begin : g_age_w_check
    $error("AGE_W too narrow to hold STARVE_LIMIT");
  end

  logic [NUM_WF-1:0]  mask;
  logic [NUM_WF-1:0]  elig;
  logic               rr_found;
  logic [WF_ID_W-1:0] rr_winner;
  logic [WF_ID_W:0]   pos;
  logic [WF_ID_W-1:0] idx;
  logic               any_elig;
  logic [WF_ID_W-1:0] winner;

  // The wf granted last cycle is still in flight, so keep it out of this search.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      mask[i] = choosen_valid && (choosen_wf_id == WF_ID_W'(i));
    end
  end

  assign elig     = ready_arry & ~mask;
  assign any_elig = |elig;

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      pos = {1'b0, rr_ptr} + (WF_ID_W+1)'(k);
      if (pos >= (WF_ID_W+1)'(NUM_WF)) pos = pos - (WF_ID_W+1)'(NUM_WF);
      idx = pos[WF_ID_W-1:0];
      if (!rr_found && elig[idx]) begin
        rr_found  = 1'b1;
        rr_winner = idx;
      end
    end
  end

`ifdef RR_ARB_STARVE_BOOST_EN
  logic [AGE_W-1:0]   age [NUM_WF];
  logic               boost_found;
  logic [WF_ID_W-1:0] boost_id;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WF; i++) begin
      if (rst || !ready_arry[i] || mask[i]) begin
        age[i] <= '0;
      end else if (age[i] != AGE_W'(STARVE_LIMIT)) begin
        age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Descending scan so the lowest-index starved wf is the one left standing.
  always_comb begin
    boost_found = 1'b0;
    boost_id    = '0;
    for (int i = NUM_WF-1; i >= 0; i--) begin
      if (elig[i] && (age[i] == AGE_W'(STARVE_LIMIT))) begin
        boost_found = 1'b1;
        boost_id    = WF_ID_W'(i);
      end
    end
  end

  assign winner = boost_found ? boost_id : rr_winner;
`else
  assign winner = rr_winner;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      choosen_valid <= 1'b0;
      choosen_wf_id <= '0;
      rr_ptr        <= '0;
    end else begin
      choosen_valid <= fu_ready && any_elig;
      if (fu_ready && any_elig) choosen_wf_id <= winner;
      if (issued_en && (issued_wf_id < WF_ID_W'(NUM_WF))) begin
        rr_ptr <= (issued_wf_id == WF_ID_W'(NUM_WF-1)) ? '0 : issued_wf_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wf_rr_issue_arbiter.sv
// Scoreboard bench for wf_rr_issue_arbiter: driver queues hand-computed
// expectations per cycle, monitor pops and compares after each clock edge.
module tb_wf_rr_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] ready_arry;
  logic        fu_ready;
  logic        issued_en;
  logic [5:0]  issued_wf_id;
  logic        choosen_valid;
  logic [5:0]  choosen_wf_id;
  logic [5:0]  rr_ptr;

  typedef struct {
    logic       v;
    logic [5:0] id;
    logic [5:0] ptr;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   tag_n = 0;

  always #5 clk = ~clk;

  wf_rr_issue_arbiter dut (
    .clk(clk),
    .rst(rst),
    .ready_arry(ready_arry),
    .fu_ready(fu_ready),
    .issued_en(issued_en),
    .issued_wf_id(issued_wf_id),
    .choosen_valid(choosen_valid),
    .choosen_wf_id(choosen_wf_id),
    .rr_ptr(rr_ptr)
  );

  function automatic logic [39:0] bits(input int a, input int b, input int c);
    logic [39:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic step(input logic r, input logic [39:0] rdy, input logic fu,
                      input logic ien, input logic [5:0] iid,
                      input logic ev, input logic [5:0] eid, input logic [5:0] eptr);
    exp_t e;
    @(negedge clk);
    rst          = r;
    ready_arry   = rdy;
    fu_ready     = fu;
    issued_en    = ien;
    issued_wf_id = iid;
    e.v   = ev;
    e.id  = eid;
    e.ptr = eptr;
    e.tag = tag_n;
    tag_n++;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (choosen_valid !== e.v) begin
          bad++;
          $display("FAIL valid step=%0d got=%0b want=%0b", e.tag, choosen_valid, e.v);
        end
        total++;
        if (rr_ptr !== e.ptr) begin
          bad++;
          $display("FAIL rr_ptr step=%0d got=%0d want=%0d", e.tag, rr_ptr, e.ptr);
        end
        if (e.v) begin
          total++;
          if (choosen_wf_id !== e.id) begin
            bad++;
            $display("FAIL wf_id step=%0d got=%0d want=%0d", e.tag, choosen_wf_id, e.id);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [39:0] r3, r0_39, r5, rs_a, rs_b;
    logic [5:0]  sid;
    rst = 1'b1; ready_arry = '0; fu_ready = 1'b0; issued_en = 1'b0; issued_wf_id = '0;
    r3    = bits(3, 7, 20);
    r0_39 = bits(0, 39, -1);
    r5    = bits(5, -1, -1);
    rs_a  = bits(2, 10, -1);
    rs_b  = bits(2, 11, -1);

    // reset and idle
    step(1, '0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0, 0, 0, 0, 0);

    // {3,7,20} with issued_en echoing each grant
    step(0, r3, 1, 0, 0,  1, 3,  0);
    step(0, r3, 1, 1, 3,  1, 7,  4);
    step(0, r3, 1, 1, 7,  1, 20, 8);
    step(0, r3, 1, 1, 20, 1, 3,  21);
    step(0, r3, 1, 1, 3,  1, 7,  4);
    step(0, '0, 1, 1, 7,  0, 0,  8);
    step(0, '0, 1, 0, 0,  0, 0,  8);

    // wrap at 39, out-of-range id ignored
    step(0, '0,    1, 1, 39, 0, 0,  0);
    step(0, r0_39, 1, 0, 0,  1, 0,  0);
    step(0, '0,    1, 1, 9,  0, 0,  10);
    step(0, '0,    1, 1, 50, 0, 0,  10);
    step(0, r0_39, 1, 0, 0,  1, 39, 10);

    // single ready wf alternates; fu_ready=0 suppresses
    step(0, r5, 1, 0, 0, 1, 5, 10);
    step(0, r5, 1, 0, 0, 0, 0, 10);
    step(0, r5, 1, 0, 0, 1, 5, 10);
    step(0, r5, 1, 0, 0, 0, 0, 10);
    step(0, r5, 0, 0, 0, 0, 0, 10);
    step(0, r5, 1, 0, 0, 1, 5, 10);
    step(0, r5, 1, 0, 0, 0, 0, 10);

    // reset with a grant in flight and rr_ptr=12
    step(0, r5, 1, 1, 11, 1, 5, 12);
    step(1, r5, 1, 1, 20, 0, 0, 0);
    step(0, '0, 1, 0, 0,  0, 0, 0);

    // starvation: wf 2 always ready, 10/11 alternate, rr_ptr pinned at 10
    step(0, '0, 1, 1, 9, 0, 0, 10);
    for (int k = 0; k < 18; k++) begin
      sid = (k % 2 == 0) ? 6'd10 : 6'd11;
`ifdef RR_ARB_STARVE_BOOST_EN
      if (k == 15) sid = 6'd2;
`endif
      step(0, (k % 2 == 0) ? rs_a : rs_b, 1, 1, 9, 1, sid, 10);
    end

    @(negedge clk);
    ready_arry = '0; issued_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
